// File: rtl/bus_to_bb_addr_rx_if.sv
// Serial bus-address in / bridge-address out bundle for bus_to_bb_addr_rx.
// addr_err exists only when BB_ADDR_RANGE_CHECK_EN is defined.
interface bus_to_bb_addr_rx_if #(
    parameter int BB_ADDR_WIDTH = 13
);
    logic                     bus_addr_sdi;
    logic                     bus_addr_sv;
    logic                     busy;
    logic [BB_ADDR_WIDTH-1:0] bb_addr;
    logic                     bb_addr_valid;
    logic                     bb_addr_ready;
`ifdef BB_ADDR_RANGE_CHECK_EN
    logic                     addr_err;
`endif

    modport slave (
        input  bus_addr_sdi,
        input  bus_addr_sv,
        input  bb_addr_ready,
        output busy,
        output bb_addr,
        output bb_addr_valid
`ifdef BB_ADDR_RANGE_CHECK_EN
        ,
        output addr_err
`endif
    );

    modport master (
        output bus_addr_sdi,
        output bus_addr_sv,
        output bb_addr_ready,
        input  busy,
        input  bb_addr,
        input  bb_addr_valid
`ifdef BB_ADDR_RANGE_CHECK_EN
        ,
        input  addr_err
`endif
    );
endinterface

// File: rtl/bus_to_bb_addr_rx.sv
// Recovers a bridge-local address from an LSB-first serial bus address.
// Optional range check (addr_err) enabled by BB_ADDR_RANGE_CHECK_EN.
module bus_to_bb_addr_rx #(
    parameter int BB_ADDR_WIDTH      = 13,
    parameter int BUS_ADDR_WIDTH     = 16,
    parameter int BUS_MEM_ADDR_WIDTH = 13
) (
    input  logic                 clk,
    input  logic                 rstn,
    bus_to_bb_addr_rx_if.slave   bus
);
    localparam int CNT_W = $clog2(BUS_ADDR_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, CHECK, HOLD} state_e;

    state_e                    state_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [BUS_ADDR_WIDTH-1:0] shreg_q;
    logic [BB_ADDR_WIDTH-1:0]  bb_addr_q;
    logic                      valid_q;

    logic [BUS_ADDR_WIDTH-1:0] shreg_d;
    logic [BB_ADDR_WIDTH-1:0]  mapped;

    // Right shift: the first (LSB) bit ends up at position 0 after a full word.
    assign shreg_d = {bus.bus_addr_sdi, shreg_q[BUS_ADDR_WIDTH-1:1]};
    assign mapped  = {shreg_q[BUS_MEM_ADDR_WIDTH], shreg_q[BB_ADDR_WIDTH-2:0]};

`ifdef BB_ADDR_RANGE_CHECK_EN
    logic legal;
    assign legal = (shreg_q[BUS_MEM_ADDR_WIDTH-1:BB_ADDR_WIDTH-1] == '0) &&
                   (shreg_q[BUS_ADDR_WIDTH-1:BUS_MEM_ADDR_WIDTH+1] == '0);
    assign bus.addr_err = (state_q == CHECK) && !legal;
`else
    // Out-of-range bits are intentionally dropped by the mapping.
    logic unused_range_bits;
    assign unused_range_bits = ^{shreg_q[BUS_MEM_ADDR_WIDTH-1:BB_ADDR_WIDTH-1],
                                 shreg_q[BUS_ADDR_WIDTH-1:BUS_MEM_ADDR_WIDTH+1]};
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shreg_q   <= '0;
            bb_addr_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.bus_addr_sv) begin
                        shreg_q <= shreg_d;
                        cnt_q   <= CNT_W'(1);
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bus.bus_addr_sv) begin
                        shreg_q <= shreg_d;
                        cnt_q   <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(BUS_ADDR_WIDTH - 1))
                            state_q <= CHECK;
                    end
                end
                CHECK: begin
`ifdef BB_ADDR_RANGE_CHECK_EN
                    if (legal) begin
                        bb_addr_q <= mapped;
                        valid_q   <= 1'b1;
                        state_q   <= HOLD;
                    end else begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end
`else
                    bb_addr_q <= mapped;
                    valid_q   <= 1'b1;
                    state_q   <= HOLD;
`endif
                end
                HOLD: begin
                    if (bus.bb_addr_ready) begin
                        valid_q <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy          = (state_q == CHECK) || (state_q == HOLD);
    assign bus.bb_addr       = bb_addr_q;
    assign bus.bb_addr_valid = valid_q;
endmodule

// File: tb/tb_bus_to_bb_addr_rx.sv
// Directed bench for bus_to_bb_addr_rx; expectations follow BB_ADDR_RANGE_CHECK_EN.
module tb_bus_to_bb_addr_rx;
    logic clk;
    logic rstn;
    int   checks = 0;
    int   errors = 0;

    bus_to_bb_addr_rx_if #(.BB_ADDR_WIDTH(13)) bif ();

    bus_to_bb_addr_rx #(
        .BB_ADDR_WIDTH(13), .BUS_ADDR_WIDTH(16), .BUS_MEM_ADDR_WIDTH(13)
    ) dut (
        .clk(clk), .rstn(rstn), .bus(bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT in the CHECK cycle (one cycle after the last bit).
    task automatic shift_addr(input logic [15:0] a, input int gap);
        for (int i = 0; i < 16; i++) begin
            bif.bus_addr_sv  = 1'b1;
            bif.bus_addr_sdi = a[i];
            tick();
            bif.bus_addr_sv  = 1'b0;
            if (i == 0) chk("busy_in_shift", 32'(bif.busy), 32'd0);
            if (i != 15) repeat (gap) tick();
        end
    endtask

    initial begin
        rstn = 1'b0;
        bif.bus_addr_sv   = 1'b0;
        bif.bus_addr_sdi  = 1'b0;
        bif.bb_addr_ready = 1'b0;
        repeat (2) tick();
        chk("rst_busy",  32'(bif.busy), 32'd0);
        chk("rst_valid", 32'(bif.bb_addr_valid), 32'd0);
        chk("rst_addr",  32'(bif.bb_addr), 32'd0);
`ifdef BB_ADDR_RANGE_CHECK_EN
        chk("rst_err",   32'(bif.addr_err), 32'd0);
`endif
        rstn = 1'b1;
        tick();

        // 0x2ABC with ready held high
        bif.bb_addr_ready = 1'b1;
        shift_addr(16'h2ABC, 0);
        chk("t1_check_busy",  32'(bif.busy), 32'd1);
        chk("t1_check_valid", 32'(bif.bb_addr_valid), 32'd0);
        tick();
        chk("t1_valid", 32'(bif.bb_addr_valid), 32'd1);
        chk("t1_addr",  32'(bif.bb_addr), 32'h1ABC);
        tick();
        chk("t1_valid_drop", 32'(bif.bb_addr_valid), 32'd0);
        chk("t1_busy_drop",  32'(bif.busy), 32'd0);
        bif.bb_addr_ready = 1'b0;

        // 0x0123 with gaps, ready withheld for 5 cycles
        shift_addr(16'h0123, 3);
        tick();
        for (int c = 0; c < 5; c++) begin
            chk("t2_hold_valid", 32'(bif.bb_addr_valid), 32'd1);
            chk("t2_hold_addr",  32'(bif.bb_addr), 32'h0123);
            tick();
        end
        bif.bb_addr_ready = 1'b1;
        tick();
        chk("t2_release_valid", 32'(bif.bb_addr_valid), 32'd0);
        chk("t2_release_busy",  32'(bif.busy), 32'd0);
        bif.bb_addr_ready = 1'b0;

        // 0x1000: bit 12 out of range
        shift_addr(16'h1000, 0);
`ifdef BB_ADDR_RANGE_CHECK_EN
        chk("t3_err_pulse", 32'(bif.addr_err), 32'd1);
        tick();
        chk("t3_err_clear", 32'(bif.addr_err), 32'd0);
        chk("t3_no_valid",  32'(bif.bb_addr_valid), 32'd0);
        chk("t3_idle",      32'(bif.busy), 32'd0);
        chk("t3_addr_kept", 32'(bif.bb_addr), 32'h0123);
`else
        tick();
        chk("t3_valid", 32'(bif.bb_addr_valid), 32'd1);
        chk("t3_addr",  32'(bif.bb_addr), 32'h0000);
        bif.bb_addr_ready = 1'b1;
        tick();
        chk("t3_release", 32'(bif.bb_addr_valid), 32'd0);
        bif.bb_addr_ready = 1'b0;
`endif

        // 0x8005: bit 15 out of range
        shift_addr(16'h8005, 1);
`ifdef BB_ADDR_RANGE_CHECK_EN
        chk("t4_err_pulse", 32'(bif.addr_err), 32'd1);
        tick();
        chk("t4_err_clear", 32'(bif.addr_err), 32'd0);
        chk("t4_no_valid",  32'(bif.bb_addr_valid), 32'd0);
        chk("t4_addr_kept", 32'(bif.bb_addr), 32'h0123);
`else
        tick();
        chk("t4_valid", 32'(bif.bb_addr_valid), 32'd1);
        chk("t4_addr",  32'(bif.bb_addr), 32'h0005);
        bif.bb_addr_ready = 1'b1;
        tick();
        chk("t4_release", 32'(bif.bb_addr_valid), 32'd0);
        bif.bb_addr_ready = 1'b0;
`endif

        // Reset after 9 of 16 bits, then a clean 0x2001
        for (int i = 0; i < 9; i++) begin
            bif.bus_addr_sv  = 1'b1;
            bif.bus_addr_sdi = 1'b1;
            tick();
        end
        bif.bus_addr_sv = 1'b0;
        rstn = 1'b0;
        tick();
        chk("t5_rst_addr",  32'(bif.bb_addr), 32'd0);
        chk("t5_rst_valid", 32'(bif.bb_addr_valid), 32'd0);
        chk("t5_rst_busy",  32'(bif.busy), 32'd0);
        rstn = 1'b1;
        bif.bb_addr_ready = 1'b1;
        shift_addr(16'h2001, 0);
        chk("t5_check_busy", 32'(bif.busy), 32'd1);
        tick();
        chk("t5_valid", 32'(bif.bb_addr_valid), 32'd1);
        chk("t5_addr",  32'(bif.bb_addr), 32'h1001);
        tick();
        chk("t5_release", 32'(bif.bb_addr_valid), 32'd0);
        bif.bb_addr_ready = 1'b0;

        // Protocol violation during HOLD of 0x0FFF
        shift_addr(16'h0FFF, 0);
        tick();
        chk("t6_valid", 32'(bif.bb_addr_valid), 32'd1);
        for (int c = 0; c < 10; c++) begin
            bif.bus_addr_sv  = 1'b1;
            bif.bus_addr_sdi = 1'($urandom);
            tick();
            chk("t6_hold_addr", 32'(bif.bb_addr), 32'h0FFF);
            chk("t6_hold_busy", 32'(bif.busy), 32'd1);
        end
        bif.bus_addr_sv   = 1'b0;
        bif.bb_addr_ready = 1'b1;
        tick();
        chk("t6_release_valid", 32'(bif.bb_addr_valid), 32'd0);
        chk("t6_release_busy",  32'(bif.busy), 32'd0);
        bif.bb_addr_ready = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
